instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Field-to-word RV32I encoder plus instruction-memory loader. It is the inverse of the control decoder.
//  It accepts one instruction per valid/ready handshake as {class, ALU op, rd, rs1, rs2, imm}.
//  The ALU op uses the decoder's ALUctl encoding. Each legal instruction is packed into a 32-bit word
//  and written to consecutive imem addresses. Used by the boot/test path to fill imem before the core runs.
// PARAMETERS
//  AW     5    imem word-address width
//  DEPTH  32   words available, 1..2**AW; loader stops at DEPTH
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  start        in   1   pulse: wr_ptr<=0, count/err cleared, enter LOAD
//  finish       in   1   pulse: end load session
//  in_valid     in   1   instruction fields valid
//  in_ready     out  1   loader accepts this cycle
//  in_class     in   3   0=R 1=I 2=LOAD 3=STORE 4=BRANCH; 5-7 illegal
//  in_aluop     in   4   ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6; used by R/I only
//  in_rd        in   5   destination register
//  in_rs1       in   5   source 1
//  in_rs2       in   5   source 2
//  in_imm       in   13  signed immediate; I/LOAD/STORE use [11:0]; BRANCH uses byte offset [12:1]
//  imem_we      out  1   write strobe, one cycle per word
//  imem_addr    out  AW  word address
//  imem_wdata   out  32  encoded instruction
//  count        out  AW+1 legal words written this session
//  err          out  1   sticky: an illegal instruction was dropped this session
//  full         out  1   count==DEPTH
//  done         out  1   one-cycle pulse when session ends
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; wr_ptr=0.
//  FSM IDLE -start-> LOAD; LOAD -finish-> IDLE (done); LOAD -count reaches DEPTH-> FULL; FULL -finish-> IDLE (done).
//  start in LOAD/FULL restarts the session: ptr/count/err cleared, pending write still completes.
//  in_ready = (state==LOAD) & ~finish. Transfer = in_valid & in_ready.
//  Latency: 1 cycle. The word transferred at cycle N appears with imem_we=1 at N+1, addr=wr_ptr@N.
//  After a legal transfer, wr_ptr increments; count increments with the write.
//  FULL is entered the cycle the DEPTH-th write issues. in_ready is 0 from that cycle.
//  No pointer wrap: the pointer is never incremented past DEPTH-1.
//  Encoding (funct3 / opcode):
//   R:   funct7=0100000 iff SUB else 0; f3 ADD/SUB 000, AND 111, OR 110, XOR 100, SLL 001, SRL 101; 0110011
//   I:   imm[11:0]; same f3 map; SLL/SRL force word[31:25]=0 (shamt=imm[4:0]); 0010011
//   LOAD:  lw, f3 010, rs2 ignored; 0000011
//   STORE: sw, f3 010, imm[11:5] rs2 rs1 010 imm[4:0]; rd ignored; 0100011
//   BRANCH: beq, f3 000, imm[12|10:5] rs2 rs1 000 imm[4:1|11]; 1100011
//  Illegal cases: class 5-7; aluop>6 for R/I; SUB with I; BRANCH with imm[0]=1.
//  An illegal instruction is still handshaken (no deadlock) but not written. err<=1; ptr/count unchanged.
//  finish and a transfer in the same cycle: in_ready is 0, so there is no transfer.
//  done pulses the cycle after finish is sampled, concurrent with any outstanding write.
//  in_valid outside LOAD is ignored. finish in IDLE is ignored (no done).
// STRUCTURE
//  Shared package: class codes, ALUctl codes (shared with control decoder), opcode/funct3/funct7 constants, FSM state enum.
//  Sub-module rv32_field_encoder: purely combinational fields->{word, legal}.
//  Top level holds FSM, pointer and output register.
// TESTING
//  add x3,x1,x2 (R,ADD) -> imem_wdata=0x002081B3, addr 0, we one cycle after handshake
//  sub x3,x1,x2 -> 0x402081B3; addi x5,x0,-1 (I,ADD,imm=0x1FFF) -> 0xFFF00293
//  lw x6,8(x2) -> 0x00812303; sw x6,12(x2) -> 0x00612623; beq x1,x2,-4 (imm=0x1FFC) -> 0xFE208EE3
//  class=6, then I/SUB, then beq imm=3 -> no imem_we, err=1, count=0, next legal word at addr 0
//  DEPTH=4, 6 back-to-back valid -> addrs 0..3 written, full=1, in_ready=0, 5th/6th held; finish -> done
//  rst mid-LOAD with write pending -> next cycle imem_we=0, all outputs 0, IDLE; start resumes at addr 0

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Shared RV32I encoding constants: instruction classes, ALUctl codes (common with the
// control decoder), opcode/funct fields and the loader FSM state type.
package instr_encoder_loader_pkg;

    localparam logic [2:0] CLS_R      = 3'd0;
    localparam logic [2:0] CLS_I      = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } load_state_e;

    // ADD and SUB share funct3; funct7 tells them apart in R-type.
    function automatic logic [2:0] alu_funct3(input logic [3:0] op);
        case (op)
            ALU_AND: alu_funct3 = 3'b111;
            ALU_OR:  alu_funct3 = 3'b110;
            ALU_XOR: alu_funct3 = 3'b100;
            ALU_SLL: alu_funct3 = 3'b001;
            ALU_SRL: alu_funct3 = 3'b101;
            default: alu_funct3 = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Instruction-field input channel (valid/ready) plus the imem write port of the loader.
interface instr_encoder_loader_if #(
    parameter int AW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_class;
    logic [3:0]    in_aluop;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [12:0]   in_imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    modport master (
        output in_valid, in_class, in_aluop, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_class, in_aluop, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader_rv32_field_encoder.sv
// Combinational RV32I field packer: {class, aluop, rd, rs1, rs2, imm} -> {word, legal}.
module rv32_field_encoder
    import instr_encoder_loader_pkg::*;
(
    input  logic [2:0]  class_i,
    input  logic [3:0]  aluop_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [12:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);
    logic [2:0]  f3;
    logic        alu_ok;
    logic        is_shift;
    logic [11:0] i_imm;

    assign f3       = alu_funct3(aluop_i);
    assign alu_ok   = (aluop_i <= ALU_SRL);
    assign is_shift = (aluop_i == ALU_SLL) || (aluop_i == ALU_SRL);
    // Immediate shifts carry only shamt; the upper seven bits must be zero for SLLI/SRLI.
    assign i_imm    = is_shift ? {7'b0, imm_i[4:0]} : imm_i[11:0];

    always_comb begin
        word_o  = '0;
        legal_o = 1'b0;
        case (class_i)
            CLS_R: begin
                word_o  = {(aluop_i == ALU_SUB) ? F7_SUB : F7_ZERO, rs2_i, rs1_i, f3, rd_i, OP_R};
                legal_o = alu_ok;
            end
            CLS_I: begin
                word_o  = {i_imm, rs1_i, f3, rd_i, OP_I};
                legal_o = alu_ok && (aluop_i != ALU_SUB);
            end
            CLS_LOAD: begin
                word_o  = {imm_i[11:0], rs1_i, F3_WORD, rd_i, OP_LOAD};
                legal_o = 1'b1;
            end
            CLS_STORE: begin
                word_o  = {imm_i[11:5], rs2_i, rs1_i, F3_WORD, imm_i[4:0], OP_STORE};
                legal_o = 1'b1;
            end
            CLS_BRANCH: begin
                word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ,
                           imm_i[4:1], imm_i[11], OP_BRANCH};
                legal_o = ~imm_i[0];
            end
            default: begin
                word_o  = '0;
                legal_o = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// Loads encoded RV32I words into consecutive imem addresses; one word per handshake,
// written one cycle later. Illegal instructions are accepted, dropped, and flagged in err_o.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  finish_i,
    instr_encoder_loader_if.slave bus,
    output logic [AW:0]           count_o,
    output logic                  err_o,
    output logic                  full_o,
    output logic                  done_o
);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LAST_C  = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

    load_state_e   state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic [31:0]   enc_word;
    logic          enc_legal;
    logic          xfer;

    rv32_field_encoder u_enc (
        .class_i (bus.in_class),
        .aluop_i (bus.in_aluop),
        .rd_i    (bus.in_rd),
        .rs1_i   (bus.in_rs1),
        .rs2_i   (bus.in_rs2),
        .imm_i   (bus.in_imm),
        .word_o  (enc_word),
        .legal_o (enc_legal)
    );

    assign bus.in_ready = (state_q == ST_LOAD) && !finish_i;
    assign xfer         = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        done_d  = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_LOAD;
            ST_LOAD: begin
                if (start_i)
                    state_d = ST_LOAD;
                else if (finish_i)
                    state_d = ST_IDLE;
                else if (xfer && enc_legal && (count_q == LAST_C))
                    state_d = ST_FULL;
            end
            ST_FULL: begin
                if (start_i)
                    state_d = ST_LOAD;
                else if (finish_i)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (xfer) begin
            if (enc_legal) begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = enc_word;
                count_d = count_q + 1'b1;
                ptr_d   = (ptr_q == PTR_MAX) ? ptr_q : ptr_q + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        if ((state_q != ST_IDLE) && finish_i && !start_i)
            done_d = 1'b1;

        // A restart clears the session counters but lets an accepted word still issue.
        if (start_i) begin
            ptr_d   = '0;
            count_d = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign count_o        = count_q;
    assign err_o          = err_q;
    assign full_o         = (count_q == DEPTH_C);
    assign done_o         = done_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding table plus session corner sequences.
module tb_instr_encoder_loader;
    import instr_encoder_loader_pkg::*;

    localparam int AW    = 3;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        finish_i = 1'b0;
    logic [AW:0] count_o;
    logic        err_o, full_o, done_o;

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder_loader_if #(.AW(AW)) bus();

    instr_encoder_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .finish_i (finish_i),
        .bus      (bus.slave),
        .count_o  (count_o),
        .err_o    (err_o),
        .full_o   (full_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cls;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[26];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] cls, input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
        bus.in_class = cls;
        bus.in_aluop = op;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_imm   = imm;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " we"},    {31'b0, bus.imem_we}, 32'd0);
        check({tag, " addr"},  {29'b0, bus.imem_addr}, 32'd0);
        check({tag, " wdata"}, bus.imem_wdata, 32'd0);
        check({tag, " count"}, {28'b0, count_o}, 32'd0);
        check({tag, " err"},   {31'b0, err_o}, 32'd0);
        check({tag, " full"},  {31'b0, full_o}, 32'd0);
        check({tag, " done"},  {31'b0, done_o}, 32'd0);
        check({tag, " ready"}, {31'b0, bus.in_ready}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{CLS_R,      ALU_ADD, 5'd3,  5'd1,  5'd2,  13'h0000, 1'b1, 32'h002081B3};
        vecs[1]  = '{CLS_R,      ALU_SUB, 5'd3,  5'd1,  5'd2,  13'h0000, 1'b1, 32'h402081B3};
        vecs[2]  = '{CLS_I,      ALU_ADD, 5'd5,  5'd0,  5'd7,  13'h1FFF, 1'b1, 32'hFFF00293};
        vecs[3]  = '{CLS_LOAD,   ALU_ADD, 5'd6,  5'd2,  5'd9,  13'h0008, 1'b1, 32'h00812303};
        vecs[4]  = '{CLS_STORE,  ALU_ADD, 5'd31, 5'd2,  5'd6,  13'h000C, 1'b1, 32'h00612623};
        vecs[5]  = '{CLS_BRANCH, ALU_ADD, 5'd9,  5'd1,  5'd2,  13'h1FFC, 1'b1, 32'hFE208EE3};
        vecs[6]  = '{CLS_R,      ALU_AND, 5'd7,  5'd8,  5'd9,  13'h0000, 1'b1, 32'h009473B3};
        vecs[7]  = '{CLS_R,      ALU_OR,  5'd1,  5'd2,  5'd3,  13'h0000, 1'b1, 32'h003160B3};
        vecs[8]  = '{CLS_R,      ALU_XOR, 5'd10, 5'd11, 5'd12, 13'h0000, 1'b1, 32'h00C5C533};
        vecs[9]  = '{CLS_R,      ALU_SLL, 5'd5,  5'd6,  5'd7,  13'h0000, 1'b1, 32'h007312B3};
        vecs[10] = '{CLS_R,      ALU_SRL, 5'd5,  5'd6,  5'd7,  13'h0000, 1'b1, 32'h007352B3};
        vecs[11] = '{CLS_I,      ALU_AND, 5'd4,  5'd5,  5'd0,  13'h00F0, 1'b1, 32'h0F02F213};
        vecs[12] = '{CLS_I,      ALU_SLL, 5'd1,  5'd1,  5'd0,  13'h0FE3, 1'b1, 32'h00309093};
        vecs[13] = '{CLS_I,      ALU_SRL, 5'd2,  5'd3,  5'd0,  13'h001F, 1'b1, 32'h01F1D113};
        vecs[14] = '{CLS_I,      ALU_OR,  5'd8,  5'd9,  5'd0,  13'h1800, 1'b1, 32'h8004E413};
        vecs[15] = '{CLS_I,      ALU_XOR, 5'd1,  5'd2,  5'd0,  13'h0005, 1'b1, 32'h00514093};
        vecs[16] = '{CLS_BRANCH, ALU_ADD, 5'd0,  5'd3,  5'd4,  13'h0008, 1'b1, 32'h00418463};
        vecs[17] = '{CLS_BRANCH, ALU_ADD, 5'd0,  5'd0,  5'd0,  13'h0800, 1'b1, 32'h000000E3};
        vecs[18] = '{CLS_STORE,  ALU_ADD, 5'd0,  5'd2,  5'd1,  13'h1FFF, 1'b1, 32'hFE112FA3};
        vecs[19] = '{3'd5,       ALU_ADD, 5'd1,  5'd1,  5'd1,  13'h0000, 1'b0, 32'h0};
        vecs[20] = '{3'd7,       ALU_ADD, 5'd1,  5'd1,  5'd1,  13'h0000, 1'b0, 32'h0};
        vecs[21] = '{CLS_R,      4'd7,    5'd1,  5'd1,  5'd1,  13'h0000, 1'b0, 32'h0};
        vecs[22] = '{CLS_I,      4'd15,   5'd1,  5'd1,  5'd1,  13'h0000, 1'b0, 32'h0};
        vecs[23] = '{CLS_I,      ALU_SUB, 5'd1,  5'd1,  5'd1,  13'h0001, 1'b0, 32'h0};
        vecs[24] = '{CLS_BRANCH, ALU_ADD, 5'd0,  5'd1,  5'd2,  13'h0003, 1'b0, 32'h0};
        vecs[25] = '{CLS_BRANCH, ALU_ADD, 5'd0,  5'd1,  5'd2,  13'h1FF1, 1'b0, 32'h0};

        bus.in_valid = 1'b0;
        drive(3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 13'd0);

        // Reset state, then stray valid/finish in IDLE must do nothing.
        tick(); tick();
        check_idle_outputs("rst_hold");
        rst = 1'b0;
        tick();
        check_idle_outputs("post_rst");
        drive(CLS_R, ALU_ADD, 5'd3, 5'd1, 5'd2, 13'd0);
        bus.in_valid = 1'b1;
        finish_i = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        finish_i = 1'b0;
        check("idle_valid we", {31'b0, bus.imem_we}, 32'd0);
        check("idle_finish done", {31'b0, done_o}, 32'd0);

        // Encoding table: a fresh session per vector, so every legal word lands at address 0.
        for (int i = 0; i < 26; i++) begin
            pulse_start();
            check($sformatf("v%0d ready", i), {31'b0, bus.in_ready}, 32'd1);
            drive(vecs[i].cls, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            check($sformatf("v%0d we", i), {31'b0, bus.imem_we}, {31'b0, vecs[i].legal});
            if (vecs[i].legal) begin
                check($sformatf("v%0d wdata", i), bus.imem_wdata, vecs[i].word);
                check($sformatf("v%0d addr", i), {29'b0, bus.imem_addr}, 32'd0);
            end
            check($sformatf("v%0d count", i), {28'b0, count_o}, {31'b0, vecs[i].legal});
            check($sformatf("v%0d err", i), {31'b0, err_o}, {31'b0, ~vecs[i].legal});
            tick();
            check($sformatf("v%0d we_drop", i), {31'b0, bus.imem_we}, 32'd0);
        end

        // Back-to-back illegal words, then the next legal one must still go to address 0.
        pulse_start();
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) drive(3'd6, ALU_ADD, 5'd1, 5'd1, 5'd1, 13'd0);
            if (k == 1) drive(CLS_I, ALU_SUB, 5'd1, 5'd1, 5'd1, 13'd4);
            if (k == 2) drive(CLS_BRANCH, ALU_ADD, 5'd0, 5'd1, 5'd2, 13'd3);
            check($sformatf("ill%0d ready", k), {31'b0, bus.in_ready}, 32'd1);
            tick();
            check($sformatf("ill%0d we", k), {31'b0, bus.imem_we}, 32'd0);
            check($sformatf("ill%0d err", k), {31'b0, err_o}, 32'd1);
            check($sformatf("ill%0d count", k), {28'b0, count_o}, 32'd0);
        end
        drive(CLS_R, ALU_ADD, 5'd3, 5'd1, 5'd2, 13'd0);
        tick();
        bus.in_valid = 1'b0;
        check("ill_next we", {31'b0, bus.imem_we}, 32'd1);
        check("ill_next addr", {29'b0, bus.imem_addr}, 32'd0);
        check("ill_next wdata", bus.imem_wdata, 32'h002081B3);
        check("ill_next err", {31'b0, err_o}, 32'd1);
        check("ill_next count", {28'b0, count_o}, 32'd1);

        // Fill to DEPTH with six back-to-back valid words; the 5th and 6th are held off.
        pulse_start();
        bus.in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(CLS_R, ALU_ADD, 5'(k + 1), 5'd1, 5'd2, 13'd0);
            check($sformatf("fill%0d ready", k), {31'b0, bus.in_ready}, (k < DEPTH) ? 32'd1 : 32'd0);
            tick();
            if (k < DEPTH) begin
                check($sformatf("fill%0d we", k), {31'b0, bus.imem_we}, 32'd1);
                check($sformatf("fill%0d addr", k), {29'b0, bus.imem_addr}, k);
                check($sformatf("fill%0d wdata", k), bus.imem_wdata,
                      32'h00208033 | (32'(k + 1) << 7));
            end else begin
                check($sformatf("fill%0d we", k), {31'b0, bus.imem_we}, 32'd0);
            end
            check($sformatf("fill%0d count", k), {28'b0, count_o}, (k < DEPTH) ? k + 1 : DEPTH);
            check($sformatf("fill%0d full", k), {31'b0, full_o}, (k >= DEPTH - 1) ? 32'd1 : 32'd0);
        end
        bus.in_valid = 1'b0;
        finish_i = 1'b1;
        tick();
        finish_i = 1'b0;
        check("full_finish done", {31'b0, done_o}, 32'd1);
        check("full_finish ready", {31'b0, bus.in_ready}, 32'd0);
        tick();
        check("full_done_pulse", {31'b0, done_o}, 32'd0);

        // finish together with valid in LOAD: no transfer, done the next cycle.
        pulse_start();
        bus.in_valid = 1'b1;
        finish_i = 1'b1;
        #1;
        check("fin_valid ready", {31'b0, bus.in_ready}, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        finish_i = 1'b0;
        check("fin_valid we", {31'b0, bus.imem_we}, 32'd0);
        check("fin_valid done", {31'b0, done_o}, 32'd1);
        check("fin_valid count", {28'b0, count_o}, 32'd0);

        // Synchronous reset in the middle of a session with a write pending.
        pulse_start();
        bus.in_valid = 1'b1;
        drive(3'd5, ALU_ADD, 5'd1, 5'd1, 5'd1, 13'd0);
        tick();
        drive(CLS_LOAD, ALU_ADD, 5'd6, 5'd2, 5'd0, 13'd8);
        tick();
        check("pre_rst count", {28'b0, count_o}, 32'd1);
        rst = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_idle_outputs("mid_rst");
        rst = 1'b0;
        pulse_start();
        drive(CLS_STORE, ALU_ADD, 5'd0, 5'd2, 5'd6, 13'd12);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("resume addr", {29'b0, bus.imem_addr}, 32'd0);
        check("resume wdata", bus.imem_wdata, 32'h00612623);
        check("resume we", {31'b0, bus.imem_we}, 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
